// File: rtl/rr_arbiter_dec.sv
// rr_arbiter_dec: round-robin arbiter, highest index first.
// Registered one-hot grant, binary index and valid; hold limit.
module rr_arbiter_dec #(
  parameter int N        = 10,
  parameter int IDXW     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid
);

  localparam int HCW =
    (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HLIM =
    HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
  localparam bit HOLD_ON = (MAX_HOLD != 0);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state;
  state_t          nstate;
  logic [IDXW-1:0] owner;
  logic [IDXW-1:0] nowner;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] nptr;
  logic [HCW-1:0]  hcnt;
  logic [HCW-1:0]  nhcnt;

  logic [N-1:0]    own_oh;
  logic [N-1:0]    others;
  logic [N-1:0]    cand;
  logic            own_req;
  logic            any_oth;
  logic            tmo;

  logic            found;
  logic [IDXW-1:0] win;
  int              sj;

  logic [N-1:0]    ngrant;
  logic [IDXW-1:0] nidx;
  logic            nvalid;

  // Split requests into owner and competitors; flag hold expiry.
  always_comb begin
    own_oh  = N'(1) << owner;
    others  = req & ~own_oh;
    own_req = |(req & own_oh);
    any_oth = |others;
    cand    = (state == BUSY) ? others : req;
    tmo     = HOLD_ON && (hcnt == HLIM) && any_oth;
  end

  // Walk ptr, ptr-1, ... wrapping below 0 to N-1; first hit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sj    = 0;
    for (int k = 0; k < N; k++) begin
      sj = int'(ptr) - k;
      if (sj < 0) sj = sj + N;
      if (!found && cand[sj]) begin
        found = 1'b1;
        win   = IDXW'(sj);
      end
    end
  end

  // Next state: new grant, release, pre-emption or hold.
  always_comb begin
    nstate = state;
    nowner = owner;
    nptr   = ptr;
    nhcnt  = hcnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          nstate = BUSY;
          nowner = win;
          nptr   = (win == '0) ? LAST : win - 1'b1;
          nhcnt  = '0;
        end
      end
      BUSY: begin
        if (!own_req || tmo) begin
          if (found) begin
            nowner = win;
            nptr   = (win == '0) ? LAST : win - 1'b1;
            nhcnt  = '0;
          end else begin
            nstate = IDLE;
            nowner = '0;
            nhcnt  = '0;
          end
        end else if (any_oth) begin
          if (hcnt != HLIM) nhcnt = hcnt + 1'b1;
        end else begin
          nhcnt = '0;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // Output decode of the next owner, registered below.
  always_comb begin
    nvalid = (nstate == BUSY);
    nidx   = '0;
    ngrant = '0;
    unique case (1'b1)
      nvalid: begin
        nidx   = nowner;
        ngrant = N'(1) << nowner;
      end
      default: ;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      ptr         <= LAST;
      hcnt        <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      state       <= nstate;
      owner       <= nowner;
      ptr         <= nptr;
      hcnt        <= nhcnt;
      grant       <= ngrant;
      grant_idx   <= nidx;
      grant_valid <= nvalid;
    end
  end

`ifndef SYNTHESIS
  a_onehot: assert property (
    @(posedge clk) $onehot0(grant));
  a_valid: assert property (
    @(posedge clk) grant_valid == (grant != '0));
  a_range: assert property (
    @(posedge clk) int'(grant_idx) < N);
  a_match: assert property (
    @(posedge clk) !grant_valid || grant[grant_idx]);
`endif

endmodule

// File: doc/rr_arbiter_dec.md
# rr_arbiter_dec

Round-robin arbiter that shares one downstream resource among 10 requesters, using the same priority order as the team's decimal-to-binary priority encoder: the highest index wins, with the start point rotated after every grant. Outputs are registered: a one-hot grant, the 4-bit binary index of the owner, and a valid flag. A grant is held until the owner drops its request, or until a hold limit expires while others are waiting. Sits between requesting blocks and a shared datapath, bus or encoder, which consumes `grant_idx` as its select.

## Interface
- `N`, 10: number of requesters.
- `IDXW`, 4: width of `grant_idx`; must satisfy 2^IDXW >= N.
- `MAX_HOLD`, 8: maximum consecutive grant cycles while another request is pending; 0 disables the limit.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  N  request vector; bit i is held high by requester i until it is done.
- `grant`  out  N  one-hot grant, registered; all zeros when idle.
- `grant_idx`  out  IDXW  binary index of the granted requester, registered; 0 when idle.
- `grant_valid`  out  1  high exactly when `grant` is non-zero.

## Operation
- State: `IDLE` / `BUSY`, plus `owner` (IDXW bits), pointer `ptr` (IDXW bits) and hold counter `hcnt` (enough bits to count to MAX_HOLD).
- Search rule:
  - Candidate order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1 (downward, wrapping).
  - The first candidate whose req bit is set wins.
  - After a grant to index i, ptr becomes i-1, or N-1 when i = 0.
- Reset: state `IDLE`, ptr = N-1, hcnt = 0, grant = 0, grant_idx = 0, grant_valid = 0.
- `IDLE`:
  - If req = 0, stay in `IDLE`.
  - Otherwise, at the next edge: grant the search winner, enter `BUSY`, set hcnt = 0 and update ptr.
- `BUSY`, evaluated every edge in this order:
  1. **Release.** req[owner] = 0. Search the remaining requests (the owner is excluded).
     - If there is a winner, grant it directly with no idle bubble and reset hcnt.
     - If not, go to `IDLE` with all outputs cleared.
  2. **Timeout.** MAX_HOLD != 0, hcnt = MAX_HOLD-1, and any req bit other than the owner's is set. Pre-empt: grant the search winner with the owner masked out, update ptr and reset hcnt. The pre-empted requester keeps its request and re-enters the rotation.
  3. **Hold.** Otherwise keep the grant.
     - hcnt increments while another request is pending, saturating at MAX_HOLD-1.
     - hcnt is held at 0 while the owner is the only requester, so a lone owner is never pre-empted.
- Invariants:
  - grant is always zero or one-hot.
  - grant[grant_idx] = 1 whenever grant_valid = 1.
  - grant_idx < N.
  - A grant is never given to a requester whose req bit is low on the deciding edge.
- Bits of req at or above N do not exist; the index range 10..15 is never produced.

## Timing
- Request-to-grant latency is 1 cycle: req sampled at edge k, grant visible after edge k.
- Release-to-next-grant latency is 1 cycle: the owner drops req before edge k, and the new grant or the idle state is visible after edge k.
- Simultaneous release by the owner and a new request arriving on the same edge: the new request is eligible at that edge.
- Timeout:
  - With another request pending continuously from the first grant cycle, the owner holds exactly MAX_HOLD cycles and loses the grant at the edge ending cycle MAX_HOLD.
  - If the owner releases on that same edge, the release rule applies. The outcome is the same winner.
- Asserting `rst` at any time, including mid-grant, immediately clears all outputs and state to their reset values without waiting for a clock edge. The first grant after deassertion follows the normal 1-cycle latency, with ptr = N-1.
- There is no combinational path from req to any output.

## Test plan
- **Reset and idle.** Hold `rst` with random req, then deassert with req = 0. Required: grant = 0, grant_idx = 0, grant_valid = 0 for 5 cycles.
- **Priority from reset.** Assert req = 10'b1000010000 (bits 9 and 4) and keep bit 9 held.
  - Required: grant_idx = 9 one cycle later.
  - Drop bit 9. Required: grant_idx = 4 next cycle, with no valid gap.
  - Drop bit 4. Required: grant_valid = 0 next cycle.
- **Rotation.** Assert all 10 bits; each owner drops its bit for one cycle after 2 grant cycles and then re-asserts. Required grant_idx sequence: 9, 8, 7, ..., 0, 9 — every index exactly once per 10 grants.
- **Timeout (MAX_HOLD = 4).** Owner 7 keeps req high and bit 2 is also asserted. Required: grant_idx = 7 for exactly 4 cycles, then 2. Bit 7 is still high, so it is granted again after 2 is either released or times out.
- **Lone owner.** Only bit 0 is asserted for 20 cycles with MAX_HOLD = 4. Required: grant_idx = 0 and grant_valid = 1 for all 20 cycles, with no pre-emption.
- **Async reset mid-grant.** While grant_idx = 5, pulse `rst` high between clock edges. Required: outputs go to 0 before the next edge. After release of reset, with req = 10'b0000100001 (bits 5 and 0) still held: grant_idx = 5, because ptr has been restored to 9.
